// File: rtl/iob_cache_writeback_channel_iob_if.sv
// Bundle between the write-back channel, the write-back controller, the cache data
// memory read port and the native back-end write port.
interface iob_cache_writeback_channel_iob_if #(
    parameter int FE_ADDR_W     = 32,
    parameter int FE_DATA_W     = 32,
    parameter int BE_ADDR_W     = 32,
    parameter int BE_DATA_W     = 32,
    parameter int WORD_OFFSET_W = 3
);
    localparam int BE_NBYTES   = BE_DATA_W / 8;
    localparam int BE_NBYTES_W = $clog2(BE_NBYTES);
    localparam int LINE2BE_W   = WORD_OFFSET_W - $clog2(BE_DATA_W / FE_DATA_W);
    localparam int LINE_ADDR_W = FE_ADDR_W - (BE_NBYTES_W + LINE2BE_W);
    localparam int MEM_ADDR_W  = (LINE2BE_W > 0) ? LINE2BE_W : 1;

    logic                   wb_valid_i;
    logic [LINE_ADDR_W-1:0] wb_addr_i;
    logic                   wb_ready_o;
    logic                   wb_done_o;
    logic [MEM_ADDR_W-1:0]  mem_addr_o;
    logic [BE_DATA_W-1:0]   mem_rdata_i;
    logic                   be_valid_o;
    logic [BE_ADDR_W-1:0]   be_addr_o;
    logic [BE_DATA_W-1:0]   be_wdata_o;
    logic [BE_NBYTES-1:0]   be_wstrb_o;
    logic                   be_ack_i;

    // The channel itself.
    modport master (
        input  wb_valid_i, wb_addr_i, mem_rdata_i, be_ack_i,
        output wb_ready_o, wb_done_o, mem_addr_o, be_valid_o, be_addr_o, be_wdata_o, be_wstrb_o
    );

    // Controller, data memory and back-end seen from the outside.
    modport slave (
        output wb_valid_i, wb_addr_i, mem_rdata_i, be_ack_i,
        input  wb_ready_o, wb_done_o, mem_addr_o, be_valid_o, be_addr_o, be_wdata_o, be_wstrb_o
    );
endinterface

// File: rtl/iob_cache_writeback_channel_iob.sv
// Write-back channel: streams one evicted line from the cache data memory to the
// back-end, one back-end word per beat, then pulses wb_done_o for one cycle.
module iob_cache_writeback_channel_iob #(
    parameter int FE_ADDR_W     = 32,
    parameter int FE_DATA_W     = 32,
    parameter int BE_ADDR_W     = 32,
    parameter int BE_DATA_W     = 32,
    parameter int WORD_OFFSET_W = 3
) (
    input logic                             clk_i,
    input logic                             reset_i,
    iob_cache_writeback_channel_iob_if.master bus
);
    localparam int BE_NBYTES   = BE_DATA_W / 8;
    localparam int BE_NBYTES_W = $clog2(BE_NBYTES);
    localparam int LINE2BE_W   = WORD_OFFSET_W - $clog2(BE_DATA_W / FE_DATA_W);
    localparam int LINE_ADDR_W = FE_ADDR_W - (BE_NBYTES_W + LINE2BE_W);
    localparam int CNT_W       = (LINE2BE_W > 0) ? LINE2BE_W : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        SEND  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                 state;
    logic [CNT_W-1:0]       cnt;
    logic [LINE_ADDR_W-1:0] addr_q;
    logic [BE_DATA_W-1:0]   wdata_q;
    logic                   wb_ready_q;
    logic                   wb_done_q;
    logic                   be_valid_q;
    logic                   last_beat;
    logic [FE_ADDR_W-1:0]   byte_addr;

    // A single-beat line has no counter; it is always on its last beat.
    assign last_beat = (LINE2BE_W == 0) || (cnt == '1);

    // NOTE: every register, including the data word, is cleared by the synchronous
    // reset so a burst abandoned by reset leaves no stale write data on the bus.
    // NOTE: state is updated with non-blocking assignments only, so every branch
    // reads the values from before the edge and no ordering hazards arise.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state      <= IDLE;
            cnt        <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            wb_ready_q <= 1'b1;
            wb_done_q  <= 1'b0;
            be_valid_q <= 1'b0;
        end else begin
            wb_done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.wb_valid_i) begin
                        addr_q     <= bus.wb_addr_i;
                        cnt        <= '0;
                        wb_ready_q <= 1'b0;
                        state      <= FETCH;
                    end
                end
                FETCH: begin
                    // cnt has driven mem_addr_o for this whole cycle.
                    wdata_q    <= bus.mem_rdata_i;
                    be_valid_q <= 1'b1;
                    state      <= SEND;
                end
                SEND: begin
                    if (bus.be_ack_i) begin
                        be_valid_q <= 1'b0;
                        if (last_beat) begin
                            wb_done_q <= 1'b1;
                            state     <= DONE;
                        end else begin
                            cnt   <= cnt + CNT_W'(1);
                            state <= FETCH;
                        end
                    end
                end
                DONE: begin
                    wb_ready_q <= 1'b1;
                    state      <= IDLE;
                end
                default: begin
                    wb_ready_q <= 1'b1;
                    be_valid_q <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end

    // {line address, beat index, byte offset}; cnt stays 0 for single-beat lines.
    assign byte_addr = (FE_ADDR_W'(addr_q) << (LINE2BE_W + BE_NBYTES_W))
                     | (FE_ADDR_W'(cnt) << BE_NBYTES_W);

    assign bus.wb_ready_o = wb_ready_q;
    assign bus.wb_done_o  = wb_done_q;
    assign bus.mem_addr_o = cnt;
    assign bus.be_valid_o = be_valid_q;
    assign bus.be_addr_o  = BE_ADDR_W'(byte_addr);
    assign bus.be_wdata_o = wdata_q;
    assign bus.be_wstrb_o = {BE_NBYTES{be_valid_q}};
endmodule

// File: tb/tb_iob_cache_writeback_channel_iob.sv
// Directed bench: a 4-beat channel (WORD_OFFSET_W=2) and a single-beat channel
// (WORD_OFFSET_W=0) driven side by side from one clock and reset.
module tb_iob_cache_writeback_channel_iob;
    logic clk_i;
    logic reset_i;
    int   total;
    int   bad;

    iob_cache_writeback_channel_iob_if #(.WORD_OFFSET_W(2)) bus4 ();
    iob_cache_writeback_channel_iob_if #(.WORD_OFFSET_W(0)) bus1 ();

    iob_cache_writeback_channel_iob #(.WORD_OFFSET_W(2)) dut4 (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .bus     (bus4)
    );

    iob_cache_writeback_channel_iob #(.WORD_OFFSET_W(0)) dut1 (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .bus     (bus1)
    );

    // Data memories with a read that settles within the cycle the address is shown.
    assign bus4.mem_rdata_i = 32'hA000_0000 | 32'(bus4.mem_addr_o);
    assign bus1.mem_rdata_i = (bus1.mem_addr_o == 1'b0) ? 32'hB000_0055 : 32'hDEAD_BEEF;

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 12; i++) begin
            bus4.wb_valid_i = 1'($urandom_range(0, 1));
            bus4.wb_addr_i  = 28'($urandom);
            bus4.be_ack_i   = 1'($urandom_range(0, 1));
            bus1.wb_valid_i = 1'($urandom_range(0, 1));
            bus1.wb_addr_i  = 30'($urandom);
            bus1.be_ack_i   = 1'($urandom_range(0, 1));
            tick();
        end
        reset_i = 1'b1;
        bus4.wb_valid_i = 1'b0;
        bus4.be_ack_i   = 1'b0;
        bus1.wb_valid_i = 1'b0;
        bus1.be_ack_i   = 1'b0;
        repeat (3) tick();
        total++;
        if ({bus4.wb_ready_o, bus4.wb_done_o, bus4.be_valid_o} !== 3'b100) begin
            bad++;
            $display("FAIL reset_ctl4: got %b want 100", {bus4.wb_ready_o, bus4.wb_done_o, bus4.be_valid_o});
        end
        total++;
        if (bus4.be_wstrb_o !== 4'h0) begin
            bad++;
            $display("FAIL reset_wstrb4: got %h want 0", bus4.be_wstrb_o);
        end
        total++;
        if (bus4.be_wdata_o !== 32'h0) begin
            bad++;
            $display("FAIL reset_wdata4: got %h want 0", bus4.be_wdata_o);
        end
        total++;
        if (bus4.be_addr_o !== 32'h0 || bus4.mem_addr_o !== 2'd0) begin
            bad++;
            $display("FAIL reset_addr4: got %h/%0d want 0/0", bus4.be_addr_o, bus4.mem_addr_o);
        end
        total++;
        if ({bus1.wb_ready_o, bus1.wb_done_o, bus1.be_valid_o, bus1.be_wstrb_o} !== 7'b100_0000) begin
            bad++;
            $display("FAIL reset_ctl1: got %b want 1000000",
                     {bus1.wb_ready_o, bus1.wb_done_o, bus1.be_valid_o, bus1.be_wstrb_o});
        end
        total++;
        if (bus1.be_wdata_o !== 32'h0 || bus1.be_addr_o !== 32'h0) begin
            bad++;
            $display("FAIL reset_data1: got %h/%h want 0/0", bus1.be_wdata_o, bus1.be_addr_o);
        end
        reset_i = 1'b0;
        tick();
    endtask

    // One 4-beat line on bus4. base is the hand-computed byte address of beat 0;
    // stall_beat waits stall_len extra cycles before ack; pulse_beat raises a stray request.
    task automatic run_line(input logic [27:0] line, input logic [31:0] base, input int stall_beat,
                            input int stall_len, input int pulse_beat, input int exp_done,
                            input string tag);
        int cyc;
        int hold;
        total++;
        if (bus4.wb_ready_o !== 1'b1) begin
            bad++;
            $display("FAIL %s_ready_start: got %b want 1", tag, bus4.wb_ready_o);
        end
        bus4.wb_valid_i = 1'b1;
        bus4.wb_addr_i  = line;
        tick();
        cyc = 1;
        bus4.wb_valid_i = 1'b0;
        total++;
        if ({bus4.wb_ready_o, bus4.be_valid_o} !== 2'b00) begin
            bad++;
            $display("FAIL %s_fetch0: got %b want 00", tag, {bus4.wb_ready_o, bus4.be_valid_o});
        end
        for (int b = 0; b < 4; b++) begin
            tick();
            cyc++;
            hold = (b == stall_beat) ? stall_len : 0;
            for (int w = 0; w <= hold; w++) begin
                total++;
                if ({bus4.be_valid_o, bus4.be_wstrb_o} !== 5'b1_1111) begin
                    bad++;
                    $display("FAIL %s_valid b%0d w%0d: got %b want 11111", tag, b, w,
                             {bus4.be_valid_o, bus4.be_wstrb_o});
                end
                total++;
                if (bus4.be_addr_o !== base + 32'(b * 4)) begin
                    bad++;
                    $display("FAIL %s_addr b%0d w%0d: got %h want %h", tag, b, w, bus4.be_addr_o,
                             base + 32'(b * 4));
                end
                total++;
                if (bus4.be_wdata_o !== 32'hA000_0000 + 32'(b)) begin
                    bad++;
                    $display("FAIL %s_data b%0d w%0d: got %h want %h", tag, b, w, bus4.be_wdata_o,
                             32'hA000_0000 + 32'(b));
                end
                if (b == pulse_beat && w == 0) begin
                    bus4.wb_valid_i = 1'b1;
                    bus4.wb_addr_i  = 28'h0FF_FFFF;
                end
                bus4.be_ack_i = (w == hold);
                tick();
                cyc++;
                bus4.wb_valid_i = 1'b0;
                bus4.be_ack_i   = 1'b0;
            end
            if (b < 3) begin
                total++;
                if ({bus4.be_valid_o, bus4.wb_done_o, bus4.be_wstrb_o} !== 6'b00_0000) begin
                    bad++;
                    $display("FAIL %s_fetch b%0d: got %b want 000000", tag, b + 1,
                             {bus4.be_valid_o, bus4.wb_done_o, bus4.be_wstrb_o});
                end
            end
        end
        total++;
        if ({bus4.wb_done_o, bus4.wb_ready_o, bus4.be_valid_o} !== 3'b100 || cyc != exp_done) begin
            bad++;
            $display("FAIL %s_done: got %b at T+%0d want 100 at T+%0d", tag,
                     {bus4.wb_done_o, bus4.wb_ready_o, bus4.be_valid_o}, cyc, exp_done);
        end
        tick();
        total++;
        if ({bus4.wb_done_o, bus4.wb_ready_o, bus4.be_valid_o} !== 3'b010) begin
            bad++;
            $display("FAIL %s_idle: got %b want 010 at T+%0d", tag,
                     {bus4.wb_done_o, bus4.wb_ready_o, bus4.be_valid_o}, cyc + 1);
        end
    endtask

    task automatic test_line();
        run_line(28'h000_1234, 32'h0001_2340, -1, 0, -1, 9, "line");
    endtask

    task automatic test_back_to_back_stall();
        run_line(28'h000_48D0, 32'h0004_8D00, 1, 3, -1, 12, "stall");
    endtask

    task automatic test_ignore_wb_valid();
        run_line(28'h000_1234, 32'h0001_2340, -1, 0, 2, 9, "ignore");
        for (int i = 0; i < 4; i++) begin
            total++;
            if ({bus4.be_valid_o, bus4.wb_ready_o, bus4.wb_done_o} !== 3'b010) begin
                bad++;
                $display("FAIL ignore_no_burst c%0d: got %b want 010", i,
                         {bus4.be_valid_o, bus4.wb_ready_o, bus4.wb_done_o});
            end
            tick();
        end
    endtask

    task automatic test_reset_mid_burst();
        bus4.wb_valid_i = 1'b1;
        bus4.wb_addr_i  = 28'h000_1234;
        tick();
        bus4.wb_valid_i = 1'b0;
        for (int b = 0; b < 2; b++) begin
            tick();
            bus4.be_ack_i = 1'b1;
            tick();
            bus4.be_ack_i = 1'b0;
        end
        tick();
        total++;
        if (bus4.be_valid_o !== 1'b1 || bus4.be_addr_o !== 32'h0001_2348) begin
            bad++;
            $display("FAIL rst_mid_send2: got %b/%h want 1/00012348", bus4.be_valid_o, bus4.be_addr_o);
        end
        reset_i = 1'b1;
        tick();
        reset_i = 1'b0;
        total++;
        if ({bus4.be_valid_o, bus4.wb_done_o, bus4.wb_ready_o} !== 3'b001 || bus4.mem_addr_o !== 2'd0) begin
            bad++;
            $display("FAIL rst_mid_after: got %b/%0d want 001/0",
                     {bus4.be_valid_o, bus4.wb_done_o, bus4.wb_ready_o}, bus4.mem_addr_o);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if ({bus4.be_valid_o, bus4.wb_done_o} !== 2'b00) begin
                bad++;
                $display("FAIL rst_mid_quiet c%0d: got %b want 00", i, {bus4.be_valid_o, bus4.wb_done_o});
            end
        end
        run_line(28'h000_1234, 32'h0001_2340, -1, 0, -1, 9, "after_rst");
    endtask

    task automatic test_single_beat();
        total++;
        if (bus1.wb_ready_o !== 1'b1) begin
            bad++;
            $display("FAIL single_ready_start: got %b want 1", bus1.wb_ready_o);
        end
        bus1.wb_valid_i = 1'b1;
        bus1.wb_addr_i  = 30'h0ABC_DEF1;
        tick();
        bus1.wb_valid_i = 1'b0;
        total++;
        if ({bus1.wb_ready_o, bus1.be_valid_o, bus1.mem_addr_o} !== 3'b000) begin
            bad++;
            $display("FAIL single_fetch: got %b want 000", {bus1.wb_ready_o, bus1.be_valid_o, bus1.mem_addr_o});
        end
        tick();
        total++;
        if ({bus1.be_valid_o, bus1.be_wstrb_o} !== 5'b1_1111 || bus1.be_addr_o !== 32'h2AF3_7BC4) begin
            bad++;
            $display("FAIL single_send: got %b/%h want 11111/2af37bc4",
                     {bus1.be_valid_o, bus1.be_wstrb_o}, bus1.be_addr_o);
        end
        total++;
        if (bus1.be_wdata_o !== 32'hB000_0055) begin
            bad++;
            $display("FAIL single_data: got %h want b0000055", bus1.be_wdata_o);
        end
        bus1.be_ack_i = 1'b1;
        tick();
        bus1.be_ack_i = 1'b0;
        total++;
        if ({bus1.wb_done_o, bus1.wb_ready_o, bus1.be_valid_o} !== 3'b100) begin
            bad++;
            $display("FAIL single_done_t3: got %b want 100", {bus1.wb_done_o, bus1.wb_ready_o, bus1.be_valid_o});
        end
        tick();
        total++;
        if ({bus1.wb_done_o, bus1.wb_ready_o, bus1.be_valid_o} !== 3'b010) begin
            bad++;
            $display("FAIL single_idle: got %b want 010", {bus1.wb_done_o, bus1.wb_ready_o, bus1.be_valid_o});
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset_i = 1'b1;
        bus4.wb_valid_i = 1'b0;
        bus4.wb_addr_i  = '0;
        bus4.be_ack_i   = 1'b0;
        bus1.wb_valid_i = 1'b0;
        bus1.wb_addr_i  = '0;
        bus1.be_ack_i   = 1'b0;
        repeat (2) tick();
        reset_i = 1'b0;
        tick();
        test_reset();
        test_line();
        test_back_to_back_stall();
        test_ignore_wb_valid();
        test_reset_mid_burst();
        test_single_beat();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
